// File: rtl/apb_completer_mem.sv
// apb_completer_mem: APB3 completer backed by a DEPTH-word register memory,
// with parameterised wait states and PSLVERR on misaligned/out-of-range addresses.
module apb_completer_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic                  r_pready, w_pready_nxt;
    logic                  r_pslverr, w_pslverr_nxt;
    logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nxt, w_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_err, w_setup, w_we;

    assign w_idx   = i_paddr >> LSB;
    // Full-width compare so high addresses never alias back into the array.
    assign w_err   = (i_paddr[LSB-1:0] != '0) || (w_idx >= DEPTH_A);
    assign w_rdata = (w_err || i_pwrite) ? '0 : r_mem[w_idx[IW-1:0]];
    assign w_setup = i_psel && !i_penable;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = r_pready;
        w_pslverr_nxt = r_pslverr;
        w_prdata_nxt  = r_prdata;
        w_we          = 1'b0;
        case (r_state)
            ACCESS: begin
                if (!i_psel || (r_pready && i_penable)) begin
                    w_we          = i_psel && i_pwrite && !r_pslverr;
                    w_state_nxt   = i_psel ? DONE : IDLE;
                    w_cnt_nxt     = '0;
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                    w_prdata_nxt  = '0;
                end else if (!r_pready && r_cnt == 4'd1) begin
                    w_cnt_nxt     = '0;
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = w_err;
                    w_prdata_nxt  = w_rdata;
                end else if (!r_pready) begin
                    w_cnt_nxt     = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt   = w_setup ? ACCESS : IDLE;
                w_cnt_nxt     = w_setup ? WS : '0;
                w_pready_nxt  = w_setup && (WS == 4'd0);
                w_pslverr_nxt = w_pready_nxt && w_err;
                w_prdata_nxt  = w_pready_nxt ? w_rdata : '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (w_we) begin
            r_mem[w_idx[IW-1:0]] <= i_pwdata;
        end
    end

    assign o_prdata  = r_prdata;
    assign o_pready  = r_pready;
    assign o_pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_completer_mem.sv
// tb_apb_completer_mem: three completers (0, 3 and 2 wait states) on shared APB
// signals with per-instance PSEL, checked against an array-based memory model.
module tb_apb_completer_mem;
    localparam int WS_TAB [3] = '{0, 3, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  psel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata [3];
    logic [2:0]  pready, pslverr;
    logic [31:0] m [3][16];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        apb_completer_mem #(.WAIT_STATES(WS_TAB[i])) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel[i]), .i_penable(penable),
            .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
            .o_prdata(prdata[i]), .o_pready(pready[i]), .o_pslverr(pslverr[i])
        );
    end

    task automatic clear_model();
        foreach (m[x, y]) m[x][y] = '0;
    endtask

    // Reference: word-addressed array, error for misaligned or beyond 16 words.
    task automatic model(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_er);
        exp_er = (a % 4 != 0) || (a / 4 >= 16);
        exp_rd = '0;
        if (!exp_er && !wr) exp_rd = m[d][a / 4];
        if (!exp_er && wr) m[d][a / 4] = wd;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int w, output logic rdy_after);
        @(negedge clk);
        psel = 3'(1 << d); penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        w = 0;
        while (pready[d] !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        rd = prdata[d];
        er = pslverr[d];
        @(posedge clk);
        #1 rdy_after = pready[d];
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        psel = '0; penable = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd, er_d, wd;
        logic er, ee, ra;
        int w;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if ({pready[d], pslverr[d], prdata[d]} !== 34'h0)
                begin fails++; $display("FAIL reset_init[%0d]: got %b/%b/%h expected 0/0/0", d, pready[d], pslverr[d], prdata[d]); end
        end
        for (int d = 0; d < 3; d++) begin
            wd = $urandom | 32'h1;
            model(d, 1'b1, 32'h8, wd, er_d, ee);
            xfer(d, 1'b1, 32'h8, wd, rd, er, w, ra);
        end
        idle(1);
        psel = 3'b010; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hCAFEF00D;
        @(negedge clk);
        penable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        for (int d = 0; d < 3; d++) begin
            tests++;
            if ({pready[d], pslverr[d], prdata[d]} !== 34'h0)
                begin fails++; $display("FAIL reset_async[%0d]: got %b/%b/%h expected 0/0/0", d, pready[d], pslverr[d], prdata[d]); end
        end
        @(negedge clk);
        psel = '0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            model(d, 1'b0, 32'h8, '0, er_d, ee);
            xfer(d, 1'b0, 32'h8, '0, rd, er, w, ra);
            tests++;
            if (rd !== 32'h0 || er !== 1'b0)
                begin fails++; $display("FAIL reset_read8[%0d]: got %h err %b expected 0 err 0", d, rd, er); end
        end
        idle(1);
    endtask

    task automatic test_basic();
        logic [31:0] rd, er_d;
        logic er, ee, ra;
        int w;
        model(0, 1'b1, 32'h4, 32'hDEADBEEF, er_d, ee);
        xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, rd, er, w, ra);
        tests++;
        if (w !== 0 || er !== 1'b0 || rd !== 32'h0)
            begin fails++; $display("FAIL basic_write: got waits %0d err %b rdata %h expected 0 0 0", w, er, rd); end
        model(0, 1'b0, 32'h4, '0, er_d, ee);
        xfer(0, 1'b0, 32'h4, '0, rd, er, w, ra);
        tests++;
        if (w !== 0 || er !== 1'b0 || rd !== 32'hDEADBEEF)
            begin fails++; $display("FAIL basic_read: got waits %0d err %b rdata %h expected 0 0 deadbeef", w, er, rd); end
        idle(1);
    endtask

    task automatic test_waits();
        logic [31:0] rd, er_d;
        logic er, ee, ra;
        int w;
        model(1, 1'b0, 32'h0, '0, er_d, ee);
        xfer(1, 1'b0, 32'h0, '0, rd, er, w, ra);
        tests++;
        if (w !== 3 || rd !== er_d || er !== 1'b0)
            begin fails++; $display("FAIL waits3_read: got waits %0d rdata %h expected 3 %h", w, rd, er_d); end
        idle(1);
    endtask

    task automatic test_errors();
        logic [31:0] rd, er_d;
        logic [31:0] addrs [3] = '{32'h41, 32'h40, 32'hFFFF_FFC0};
        logic er, ee, ra;
        int w;
        model(0, 1'b1, 32'h0, 32'h600DF00D, er_d, ee);
        xfer(0, 1'b1, 32'h0, 32'h600DF00D, rd, er, w, ra);
        foreach (addrs[k]) begin
            model(0, 1'b1, addrs[k], 32'h12345678, er_d, ee);
            xfer(0, 1'b1, addrs[k], 32'h12345678, rd, er, w, ra);
            tests++;
            if (er !== 1'b1 || w !== 0 || rd !== 32'h0)
                begin fails++; $display("FAIL err_addr %h: got err %b waits %0d rdata %h expected 1 0 0", addrs[k], er, w, rd); end
        end
        model(0, 1'b0, 32'h0, '0, er_d, ee);
        xfer(0, 1'b0, 32'h0, '0, rd, er, w, ra);
        tests++;
        if (rd !== er_d || er !== 1'b0)
            begin fails++; $display("FAIL err_mem_intact: got %h err %b expected %h err 0", rd, er, er_d); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, er_d;
        logic er, ee, ra;
        int w;
        time t0;
        model(0, 1'b1, 32'h3C, 32'hA5A5A5A5, er_d, ee);
        xfer(0, 1'b1, 32'h3C, 32'hA5A5A5A5, rd, er, w, ra);
        t0 = $time;
        tests++;
        if (ra !== 1'b0)
            begin fails++; $display("FAIL b2b_done_ready: got %b expected 0", ra); end
        model(0, 1'b0, 32'h3C, '0, er_d, ee);
        xfer(0, 1'b0, 32'h3C, '0, rd, er, w, ra);
        tests++;
        if (rd !== 32'hA5A5A5A5 || er !== 1'b0 || w !== 0)
            begin fails++; $display("FAIL b2b_read: got %h err %b waits %0d expected a5a5a5a5 0 0", rd, er, w); end
        tests++;
        if ($time - t0 !== 20)
            begin fails++; $display("FAIL b2b_cycles: got %0t expected 20", $time - t0); end
        idle(1);
    endtask

    task automatic test_abort();
        logic [31:0] rd, er_d, v;
        logic er, ee, ra, seen;
        int w;
        v = $urandom;
        model(2, 1'b1, 32'h8, v, er_d, ee);
        xfer(2, 1'b1, 32'h8, v, rd, er, w, ra);
        idle(1);
        psel = 3'b100; pwrite = 1'b1; paddr = 32'h8; pwdata = ~v;
        @(negedge clk);
        penable = 1'b1;
        seen = pready[2];
        @(negedge clk);
        seen |= pready[2];
        psel = '0; penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= pready[2];
        end
        tests++;
        if (seen !== 1'b0)
            begin fails++; $display("FAIL abort_pready: got %b expected 0", seen); end
        model(2, 1'b0, 32'h8, '0, er_d, ee);
        xfer(2, 1'b0, 32'h8, '0, rd, er, w, ra);
        tests++;
        if (rd !== v || w !== 2)
            begin fails++; $display("FAIL abort_mem: got %h waits %0d expected %h 2", rd, w, v); end
        idle(1);
    endtask

    task automatic test_spurious();
        logic [31:0] rd, er_d;
        logic er, ee, ra;
        int w;
        psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (pready[0] !== 1'b0)
                begin fails++; $display("FAIL spurious_enable[%0d]: got pready %b expected 0", k, pready[0]); end
        end
        idle(1);
        model(0, 1'b0, 32'h0, '0, er_d, ee);
        xfer(0, 1'b0, 32'h0, '0, rd, er, w, ra);
        tests++;
        if (rd !== er_d)
            begin fails++; $display("FAIL spurious_mem: got %h expected %h", rd, er_d); end
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] rd, er_d, a, wd;
        logic er, ee, ra;
        bit wr;
        int w, d;
        for (int k = 0; k < 80; k++) begin
            d = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            case ($urandom_range(0, 9))
                6:       a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
                7:       a = $urandom_range(16, 1000) * 4;
                8:       a = 32'hFFFF_FFFC;
                9:       a = 32'h40;
                default: a = $urandom_range(0, 15) * 4;
            endcase
            model(d, wr, a, wd, er_d, ee);
            xfer(d, wr, a, wd, rd, er, w, ra);
            tests++;
            if (rd !== er_d || er !== ee)
                begin fails++; $display("FAIL rand[%0d] d%0d %s %h: got %h err %b expected %h err %b", k, d, wr ? "wr" : "rd", a, rd, er, er_d, ee); end
            tests++;
            if (w !== WS_TAB[d] || ra !== 1'b0)
                begin fails++; $display("FAIL rand_timing[%0d] d%0d: got waits %0d ready_after %b expected %0d 0", k, d, w, ra, WS_TAB[d]); end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_waits();
        test_errors();
        test_back_to_back();
        test_abort();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
